// File: rtl/ahb_master_addr_gen.sv
// AHB master address-phase sequencer: turns one burst command into an HTRANS/HADDR sequence.
// Optional AHB_INCR_1KB_SPLIT_EN restarts INCR-type bursts (NONSEQ, HBURST=INCR) at 1KB boundaries.
module ahb_master_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  output logic [1:0]            HTRANS,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  output logic                  beat_acc,
  output logic                  burst_done,
  output logic                  burst_err
);

  localparam int CW = (LEN_WIDTH > 5) ? LEN_WIDTH : 5;

  typedef enum logic [1:0] {TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3} htrans_t;
  typedef enum logic [2:0] {SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
                            WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7} hburst_t;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF_WORD = 3'd1, WORD = 3'd2} hsize_t;
  typedef enum logic [1:0] {OKAY = 2'd0, ERROR = 2'd1, RETRY = 2'd2, SPLIT = 2'd3} hresp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         remain;
  logic                  is_wrap;
  logic                  err_wait;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [ADDR_WIDTH-1:0] cap_mask;
  logic [CW-1:0]         cap_beats;
  logic                  cap_wrap;
  logic                  cmd_fire;
  logic                  split_here;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign step     = ADDR_WIDTH'(1) << HSIZE;
  assign cap_addr = cmd_addr & ~((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1));
  assign cap_wrap = (cmd_burst == WRAP4) || (cmd_burst == WRAP8) || (cmd_burst == WRAP16);
  assign cap_mask = (ADDR_WIDTH'(cap_beats) << cmd_size) - ADDR_WIDTH'(1);
  assign beat_acc = ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ)) && HREADY;

  // Wrapping bursts keep the upper bits and let only the in-boundary bits roll over.
  always_comb begin
    next_addr = HADDR + step;
    if (is_wrap) begin
      next_addr = (HADDR & ~wrap_mask) | ((HADDR + step) & wrap_mask);
    end
  end

  always_comb begin
    cap_beats = CW'(1);
    case (cmd_burst)
      INCR:          if (cmd_len != '0) cap_beats = CW'(cmd_len);
      WRAP4, INCR4:  cap_beats = CW'(4);
      WRAP8, INCR8:  cap_beats = CW'(8);
      WRAP16, INCR16: cap_beats = CW'(16);
      default:       cap_beats = CW'(1);
    endcase
  end

`ifdef AHB_INCR_1KB_SPLIT_EN
  assign split_here = !is_wrap && (next_addr[9:0] == 10'd0);
`else
  assign split_here = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      HTRANS     <= TR_IDLE;
      HADDR      <= '0;
      HBURST     <= SINGLE;
      HSIZE      <= BYTE;
      HWRITE     <= 1'b0;
      remain     <= '0;
      is_wrap    <= 1'b0;
      wrap_mask  <= '0;
      err_wait   <= 1'b0;
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_size > WORD) begin
              burst_done <= 1'b1;
              burst_err  <= 1'b1;
            end else begin
              state     <= ST_ADDR;
              cmd_ready <= 1'b0;
              HTRANS    <= TR_NONSEQ;
              HADDR     <= cap_addr;
              HBURST    <= cmd_burst;
              HSIZE     <= cmd_size;
              HWRITE    <= cmd_write;
              remain    <= cap_beats;
              is_wrap   <= cap_wrap;
              wrap_mask <= cap_mask;
              err_wait  <= 1'b0;
            end
          end
        end
        // After the first ERROR cycle the bus is idled; the second cycle (HREADY high) ends the command.
        ST_ADDR, ST_DRAIN: begin
          if (err_wait) begin
            if (HREADY) begin
              state      <= ST_IDLE;
              cmd_ready  <= 1'b1;
              err_wait   <= 1'b0;
              burst_done <= 1'b1;
              burst_err  <= 1'b1;
            end
          end else if ((HRESP == ERROR) && !HREADY) begin
            err_wait <= 1'b1;
            HTRANS   <= TR_IDLE;
          end else if (HREADY) begin
            if (state == ST_DRAIN) begin
              state      <= ST_IDLE;
              cmd_ready  <= 1'b1;
              burst_done <= 1'b1;
            end else if (remain == CW'(1)) begin
              HTRANS <= TR_IDLE;
              state  <= ST_DRAIN;
            end else begin
              remain <= remain - CW'(1);
              HADDR  <= next_addr;
              if (split_here) begin
                HTRANS <= TR_NONSEQ;
                HBURST <= INCR;
              end else begin
                HTRANS <= TR_SEQ;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_addr_gen.sv
// Directed scoreboard bench for ahb_master_addr_gen; expected beats are queued at command time
// and popped on every accepted address phase. Expectations follow AHB_INCR_1KB_SPLIT_EN if defined.
module tb_ahb_master_addr_gen;

  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;
  localparam logic [2:0] B_WRAP8 = 3'd4, B_INCR8 = 3'd5, B_INCR16 = 3'd7;
  localparam logic [2:0] SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_WORD = 3'd2;
  localparam logic [1:0] R_OKAY = 2'd0, R_ERROR = 2'd1;
  localparam logic [31:0] NO_ADDR = 32'h5555_5550;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
  } beat_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [7:0]  cmd_len;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        beat_acc;
  logic        burst_done;
  logic        burst_err;

  beat_t expq[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_addr_gen dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write), .cmd_len(cmd_len),
    .HREADY(HREADY), .HRESP(HRESP),
    .HTRANS(HTRANS), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .beat_acc(beat_acc), .burst_done(burst_done), .burst_err(burst_err)
  );

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input logic [31:0] addr, input logic [1:0] trans, input logic [2:0] burst,
                          input logic [2:0] size, input logic write);
    beat_t b;
    b.addr = addr; b.trans = trans; b.burst = burst; b.size = size; b.write = write;
    expq.push_back(b);
  endtask

  task automatic popCheck(input string tag);
    beat_t b;
    checkOutput({tag, "_beat_expected"}, 32'(expq.size() > 0), 1);
    if (expq.size() > 0) begin
      b = expq.pop_front();
      checkOutput({tag, "_haddr"}, HADDR, b.addr);
      checkOutput({tag, "_htrans"}, 32'(HTRANS), 32'(b.trans));
      checkOutput({tag, "_hburst"}, 32'(HBURST), 32'(b.burst));
      checkOutput({tag, "_hsize"}, 32'(HSIZE), 32'(b.size));
      checkOutput({tag, "_hwrite"}, 32'(HWRITE), 32'(b.write));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [2:0] burst,
                               input logic [2:0] size, input logic write, input logic [7:0] len);
    cmd_addr  = addr;
    cmd_burst = burst;
    cmd_size  = size;
    cmd_write = write;
    cmd_len   = len;
    cmd_valid = 1'b1;
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drives HREADY/HRESP per cycle index n (0 = first NONSEQ cycle) until burst_done or budget.
  task automatic runUntilDone(input string tag, input int budget, input logic expErr,
                              input int stallStart, input int stallLen, input int errAt,
                              input logic [31:0] forbidAddr);
    bit    done = 0;
    bit    forbidSeen = 0;
    int    n = 0;
    beat_t held;
    while (!done && n < budget) begin
      HREADY = !(n >= stallStart && n < stallStart + stallLen);
      HRESP  = R_OKAY;
      if (errAt >= 0 && (n == errAt || n == errAt + 1)) begin
        HRESP  = R_ERROR;
        HREADY = (n == errAt + 1);
      end
      #1;
      if (HTRANS != T_IDLE && HADDR == forbidAddr) forbidSeen = 1;
      if (errAt >= 0 && n == errAt + 1)
        checkOutput({tag, "_idle_after_err"}, 32'(HTRANS), 32'(T_IDLE));
      if (!HREADY && HRESP == R_OKAY && HTRANS != T_IDLE && expq.size() > 0) begin
        held = expq[0];
        checkOutput({tag, "_held_addr"}, HADDR, held.addr);
        checkOutput({tag, "_held_trans"}, 32'(HTRANS), 32'(held.trans));
      end
      if (beat_acc) popCheck(tag);
      tick();
      n++;
      if (burst_done) done = 1;
    end
    HREADY = 1'b1;
    HRESP  = R_OKAY;
    checkOutput({tag, "_done"}, 32'(done), 1);
    checkOutput({tag, "_err"}, 32'(burst_err), 32'(expErr));
    checkOutput({tag, "_left"}, 32'(expq.size()), 0);
    checkOutput({tag, "_forbid"}, 32'(forbidSeen), 0);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 1);
    expq.delete();
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0;
    cmd_write = 1'b0; cmd_len = '0; HREADY = 1'b1; HRESP = R_OKAY;
    tick();
    tick();
    HRESET = 1'b0;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_htrans", 32'(HTRANS), 32'(T_IDLE));
    checkOutput("rst_haddr", HADDR, 0);
    checkOutput("rst_hburst", 32'(HBURST), 32'(B_SINGLE));
    checkOutput("rst_hsize", 32'(HSIZE), 32'(SZ_BYTE));
    checkOutput("rst_hwrite", 32'(HWRITE), 0);
    checkOutput("rst_done", 32'(burst_done), 0);
    checkOutput("rst_err", 32'(burst_err), 0);
    checkOutput("rst_beat_acc", 32'(beat_acc), 0);

    // Zero-wait SINGLE with exact cycle timing
    pushBeat(32'h100, T_NONSEQ, B_SINGLE, SZ_WORD, 1'b1);
    applyStimulus("single", 32'h100, B_SINGLE, SZ_WORD, 1'b1, 8'd0);
    checkOutput("single_t1_ready", 32'(cmd_ready), 0);
    #1;
    checkOutput("single_t1_beat_acc", 32'(beat_acc), 1);
    popCheck("single_t1");
    tick();
    checkOutput("single_t2_htrans", 32'(HTRANS), 32'(T_IDLE));
    checkOutput("single_t2_done", 32'(burst_done), 0);
    tick();
    checkOutput("single_t3_done", 32'(burst_done), 1);
    checkOutput("single_t3_err", 32'(burst_err), 0);
    checkOutput("single_t3_ready", 32'(cmd_ready), 1);

    pushBeat(32'h38, T_NONSEQ, B_WRAP4, SZ_WORD, 1'b0);
    pushBeat(32'h3C, T_SEQ, B_WRAP4, SZ_WORD, 1'b0);
    pushBeat(32'h30, T_SEQ, B_WRAP4, SZ_WORD, 1'b0);
    pushBeat(32'h34, T_SEQ, B_WRAP4, SZ_WORD, 1'b0);
    applyStimulus("wrap4", 32'h38, B_WRAP4, SZ_WORD, 1'b0, 8'd0);
    runUntilDone("wrap4", 20, 1'b0, -1, 0, -1, NO_ADDR);

    for (int i = 0; i < 8; i++)
      pushBeat(32'h10 + 32'(2 * i), (i == 0) ? T_NONSEQ : T_SEQ, B_INCR8, SZ_HALF, 1'b1);
    applyStimulus("incr8_stall", 32'h10, B_INCR8, SZ_HALF, 1'b1, 8'd0);
    runUntilDone("incr8_stall", 30, 1'b0, 2, 2, -1, NO_ADDR);

    pushBeat(32'h3FF, T_NONSEQ, B_INCR, SZ_BYTE, 1'b0);
`ifdef AHB_INCR_1KB_SPLIT_EN
    pushBeat(32'h400, T_NONSEQ, B_INCR, SZ_BYTE, 1'b0);
`else
    pushBeat(32'h400, T_SEQ, B_INCR, SZ_BYTE, 1'b0);
`endif
    pushBeat(32'h401, T_SEQ, B_INCR, SZ_BYTE, 1'b0);
    applyStimulus("incr_1kb", 32'h3FF, B_INCR, SZ_BYTE, 1'b0, 8'd3);
    runUntilDone("incr_1kb", 20, 1'b0, -1, 0, -1, NO_ADDR);

    pushBeat(32'h3F8, T_NONSEQ, B_INCR4, SZ_WORD, 1'b1);
    pushBeat(32'h3FC, T_SEQ, B_INCR4, SZ_WORD, 1'b1);
`ifdef AHB_INCR_1KB_SPLIT_EN
    pushBeat(32'h400, T_NONSEQ, B_INCR, SZ_WORD, 1'b1);
    pushBeat(32'h404, T_SEQ, B_INCR, SZ_WORD, 1'b1);
`else
    pushBeat(32'h400, T_SEQ, B_INCR4, SZ_WORD, 1'b1);
    pushBeat(32'h404, T_SEQ, B_INCR4, SZ_WORD, 1'b1);
`endif
    applyStimulus("incr4_1kb", 32'h3F8, B_INCR4, SZ_WORD, 1'b1, 8'd0);
    runUntilDone("incr4_1kb", 20, 1'b0, -1, 0, -1, NO_ADDR);

    // len 0 behaves as one beat; low address bits are cleared for WORD
    pushBeat(32'h20, T_NONSEQ, B_INCR, SZ_WORD, 1'b0);
    applyStimulus("incr_len0", 32'h23, B_INCR, SZ_WORD, 1'b0, 8'd0);
    runUntilDone("incr_len0", 20, 1'b0, -1, 0, -1, NO_ADDR);

    pushBeat(32'h05, T_NONSEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h06, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h07, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h00, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h01, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h02, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h03, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    pushBeat(32'h04, T_SEQ, B_WRAP8, SZ_BYTE, 1'b0);
    applyStimulus("wrap8", 32'h05, B_WRAP8, SZ_BYTE, 1'b0, 8'd0);
    runUntilDone("wrap8", 30, 1'b0, 3, 1, -1, NO_ADDR);

    pushBeat(32'hFFFF_FFF8, T_NONSEQ, B_INCR4, SZ_WORD, 1'b0);
    pushBeat(32'hFFFF_FFFC, T_SEQ, B_INCR4, SZ_WORD, 1'b0);
`ifdef AHB_INCR_1KB_SPLIT_EN
    pushBeat(32'h0, T_NONSEQ, B_INCR, SZ_WORD, 1'b0);
    pushBeat(32'h4, T_SEQ, B_INCR, SZ_WORD, 1'b0);
`else
    pushBeat(32'h0, T_SEQ, B_INCR4, SZ_WORD, 1'b0);
    pushBeat(32'h4, T_SEQ, B_INCR4, SZ_WORD, 1'b0);
`endif
    applyStimulus("incr4_rollover", 32'hFFFF_FFF8, B_INCR4, SZ_WORD, 1'b0, 8'd0);
    runUntilDone("incr4_rollover", 20, 1'b0, -1, 0, -1, NO_ADDR);

    // ERROR on the data phase of 0x4 while 0x8 is driven; 0xC must never appear
    pushBeat(32'h0, T_NONSEQ, B_INCR4, SZ_WORD, 1'b1);
    pushBeat(32'h4, T_SEQ, B_INCR4, SZ_WORD, 1'b1);
    applyStimulus("incr4_err", 32'h0, B_INCR4, SZ_WORD, 1'b1, 8'd0);
    runUntilDone("incr4_err", 20, 1'b1, -1, 0, 2, 32'hC);

    applyStimulus("reject", 32'h200, B_SINGLE, 3'b011, 1'b0, 8'd0);
    #1;
    checkOutput("reject_htrans", 32'(HTRANS), 32'(T_IDLE));
    checkOutput("reject_beat_acc", 32'(beat_acc), 0);
    checkOutput("reject_done", 32'(burst_done), 1);
    checkOutput("reject_err", 32'(burst_err), 1);
    checkOutput("reject_ready", 32'(cmd_ready), 1);
    tick();
    checkOutput("reject_done_clear", 32'(burst_done), 0);
    checkOutput("reject_still_idle", 32'(HTRANS), 32'(T_IDLE));

    applyStimulus("rst_mid", 32'h1000, B_INCR16, SZ_WORD, 1'b1, 8'd0);
    tick();
    tick();
    tick();
    checkOutput("rst_mid_pre_addr", HADDR, 32'h100C);
    HRESET = 1'b1;
    tick();
    checkOutput("rst_mid_htrans", 32'(HTRANS), 32'(T_IDLE));
    checkOutput("rst_mid_haddr", HADDR, 0);
    checkOutput("rst_mid_hburst", 32'(HBURST), 32'(B_SINGLE));
    checkOutput("rst_mid_hsize", 32'(HSIZE), 32'(SZ_BYTE));
    checkOutput("rst_mid_hwrite", 32'(HWRITE), 0);
    checkOutput("rst_mid_ready", 32'(cmd_ready), 1);
    checkOutput("rst_mid_done", 32'(burst_done), 0);
    checkOutput("rst_mid_err", 32'(burst_err), 0);
    checkOutput("rst_mid_beat_acc", 32'(beat_acc), 0);
    HRESET = 1'b0;
    tick();
    checkOutput("rst_after_done", 32'(burst_done), 0);
    checkOutput("rst_after_err", 32'(burst_err), 0);
    checkOutput("rst_after_htrans", 32'(HTRANS), 32'(T_IDLE));

    $display("[TB] directed sequence complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_master_addr_gen.md
# ahb_master_addr_gen

- Address-phase sequencer for the AHB master path.
- Accepts one burst command per handshake and drives a protocol-correct HTRANS/HADDR/HBURST/HSIZE/HWRITE sequence.
- Honours HREADY stalls and the two-cycle ERROR response.
- Sits between the master's command source and the bus: its outputs feed the arbiter/decoder; HREADY/HRESP come back from the slave mux.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `LEN_WIDTH`, 8, beat-count width for undefined-length INCR.
- `HCLK` in 1: clock.
- `HRESET` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` in ADDR_WIDTH: start address. Low `cmd_size` bits are forced to 0 on capture.
- `cmd_burst` in 3: `hburst_t` value.
- `cmd_size` in 3: `hsize_t` value (BYTE/HALF_WORD/WORD).
- `cmd_write` in 1: transfer direction.
- `cmd_len` in LEN_WIDTH: beat count, used for INCR only. 0 is treated as 1.
- `HREADY` in 1: bus ready.
- `HRESP` in 2: `hresp_t` value.
- `HTRANS` out 2, `HADDR` out ADDR_WIDTH, `HBURST` out 3, `HSIZE` out 3, `HWRITE` out 1: bus address/control.
- `beat_acc` out 1: one-cycle pulse when an address phase is accepted (`HTRANS` is NONSEQ/SEQ and `HREADY` is high).
- `burst_done` out 1: one-cycle pulse when the command finishes.
- `burst_err` out 1: one-cycle pulse, concurrent with `burst_done`, when the command ended by ERROR or was rejected.

## Operation
- States: IDLE, ADDR, DRAIN.
- **IDLE**
  - `cmd_ready`=1, `HTRANS`=IDLE.
  - On handshake: capture the command.
  - Beats: SINGLE=1, INCR=`cmd_len`, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
  - Go to ADDR.
  - `cmd_size` > WORD: reject. No bus activity; `burst_done`+`burst_err` pulse next cycle; stay IDLE.
- **ADDR**
  - First beat: NONSEQ. Later beats: SEQ.
  - All outputs are held while `HREADY`=0.
  - On `HREADY`=1, advance the address and decrement remaining beats.
  - When the last address is accepted, go to DRAIN with `HTRANS`=IDLE.
- **DRAIN**
  - `HTRANS`=IDLE. Wait for `HREADY`=1, which completes the final data phase.
  - Pulse `burst_done` the following cycle and return to IDLE.
- Address arithmetic, with `step = 1<<size`:
  - INCR types: `next = addr + step`.
  - WRAP types, with `bnd = beats*step`: `next = (addr & ~(bnd-1)) | ((addr+step) & (bnd-1))`.
  - Computed at ADDR_WIDTH; wraps modulo 2^ADDR_WIDTH.
- ERROR (state ADDR or DRAIN):
  - Trigger: `HRESP`=ERROR with `HREADY`=0 (first error cycle).
  - Next cycle: `HTRANS`=IDLE and remaining beats are cancelled.
  - When `HREADY`=1 (second error cycle): pulse `burst_done`+`burst_err` next cycle, go to IDLE.
  - An address accepted in the same cycle as the second error cycle does not count.
- `cmd_ready`=0 in ADDR and DRAIN; commands are not pipelined.
- Reset: synchronous. Overrides everything, including mid-burst; no pulses are generated.
- Reset values:
  - State IDLE.
  - `cmd_ready`=1, `HTRANS`=IDLE, `HADDR`=0, `HBURST`=SINGLE, `HSIZE`=BYTE, `HWRITE`=0.
  - `beat_acc`=`burst_done`=`burst_err`=0.

## Timing
- All bus outputs and `cmd_ready` are registered.
- Handshake at cycle T → NONSEQ with `cmd_addr` driven at T+1.
- Each accepted beat → next address at +1 cycle. Zero-wait burst of N beats occupies T+1..T+N.
- `beat_acc` is combinational from `HTRANS`/`HREADY`.
- `burst_done`/`burst_err` are registered, one cycle after the completing `HREADY`.
- Zero-wait SINGLE: NONSEQ at T+1, IDLE at T+2, `burst_done` at T+3, next handshake possible at T+3.

## Configuration
- Macro: `AHB_INCR_1KB_SPLIT_EN`.
- Defined:
  - For INCR-type bursts, a non-first beat whose address has `addr[9:0]==0` is driven NONSEQ with `HBURST`=INCR.
  - `HBURST` stays INCR for the remainder of the burst.
  - WRAP types are unaffected.
- Undefined: SEQ continues across 1KB; the command source guarantees legality.

## Test plan
- SINGLE WORD write at 0x100, `HREADY`=1 → T+1: NONSEQ 0x100 `HWRITE`=1; T+2: IDLE; `burst_done` at T+3; `burst_err`=0.
- WRAP4 WORD read at 0x38 → addresses 0x38,0x3C,0x30,0x34 with N,S,S,S, then IDLE; four `beat_acc` pulses.
- INCR8 HALF_WORD at 0x10, `HREADY`=0 for 2 cycles while 0x14 is driven → 0x14/SEQ held 3 cycles total, then 0x16…0x1E.
- INCR, `cmd_len`=3, BYTE at 0x3FF:
  - Macro defined → 0x3FF N, 0x400 N with `HBURST`=INCR, 0x401 S.
  - Macro undefined → 0x400 S.
- INCR4 WORD at 0x0, ERROR on the data phase of 0x4 (two cycles) while 0x8/SEQ is driven → `HTRANS`=IDLE after the first error cycle; 0xC is never driven; `burst_done`+`burst_err` pulse.
- `cmd_size`=3'b011 → no NONSEQ, `burst_err` pulse.
- `HRESET` asserted mid-INCR16 → next cycle all outputs at reset values, `cmd_ready`=1, no pulses.
